// File: rtl/flash_sample_sequencer_if.sv
// ---------------------------------------------------------------------------
// flash_sample_sequencer_if
// Read-side bus between the audio sample sequencer and the flash controller.
//   flash_read          master -> slave  read request, held until accepted
//   flash_address       master -> slave  word address of the request
//   flash_byteenable    master -> slave  always all four bytes
//   flash_waitrequest   slave -> master  controller busy, request not taken
//   flash_readdatavalid slave -> master  flash_readdata carries a word
//   flash_readdata      slave -> master  32-bit flash word
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface flash_sample_sequencer_if #(
   parameter int ADDR_W = 23
);
   logic              flash_read;
   logic [ADDR_W-1:0] flash_address;
   logic [3:0]        flash_byteenable;
   logic              flash_waitrequest;
   logic              flash_readdatavalid;
   logic [31:0]       flash_readdata;

   // The sequencer issues reads, so it is the master of this bus.
   modport master (
      output flash_read,
      output flash_address,
      output flash_byteenable,
      input  flash_waitrequest,
      input  flash_readdatavalid,
      input  flash_readdata
   );

   // The flash controller answers the reads.
   modport slave (
      input  flash_read,
      input  flash_address,
      input  flash_byteenable,
      output flash_waitrequest,
      output flash_readdatavalid,
      output flash_readdata
   );
endinterface

// File: rtl/flash_sample_sequencer.sv
// ---------------------------------------------------------------------------
// flash_sample_sequencer
// Feeds 16-bit audio samples to the output stage, one per sample_tick while
// playing. Each 32-bit flash word holds two samples, so one flash read is
// issued per pair of ticks. The word address walks forward or backward
// through [START_ADDR, END_ADDR] with wrap-around; pause and restart are
// supported.
//   clk             system clock
//   rst_n           asynchronous reset, active low
//   i_sample_tick   one-cycle request for the next sample
//   i_play          1 = run, 0 = pause
//   i_dir           0 = forward, 1 = backward
//   i_restart       one-cycle pulse, jump to region start/end
//   flash           flash read bus (master side)
//   o_sample_out    current sample, two's complement
//   o_sample_valid  one-cycle pulse when o_sample_out updates
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module flash_sample_sequencer #(
   parameter int                ADDR_W     = 23,
   parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
   parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_sample_tick,
   input  logic                     i_play,
   input  logic                     i_dir,
   input  logic                     i_restart,
   flash_sample_sequencer_if.master flash,
   output logic [15:0]              o_sample_out,
   output logic                     o_sample_valid
);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT_DATA,
      OUT_FIRST,
      WAIT_TICK,
      OUT_SECOND
   } state_t;

   state_t            r_state;
   logic              r_read;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_data;
   logic              r_dirQ;
   logic              r_restartPend;
   logic [15:0]       r_sampleOut;
   logic              r_sampleValid;

   logic              w_restartNow;
   logic              w_tickGo;
   logic [ADDR_W-1:0] w_restartAddr;
   logic [ADDR_W-1:0] w_nextAddr;

   // A restart either arrives this cycle or is still waiting from an earlier
   // state; both are honoured the same way. The restart target follows the
   // live direction input, not the direction latched for the current word.
   assign w_restartNow  = r_restartPend | i_restart;
   assign w_tickGo      = i_sample_tick & i_play;
   assign w_restartAddr = i_dir ? END_ADDR : START_ADDR;

   // Address of the next word once both halves of the current word are out,
   // wrapping at the region edges in whichever direction the word was read.
   always_comb begin
      w_nextAddr = r_addr;
      if (r_dirQ) begin
         w_nextAddr = (r_addr == START_ADDR) ? END_ADDR : r_addr - ADDR_W'(1);
      end else begin
         w_nextAddr = (r_addr == END_ADDR) ? START_ADDR : r_addr + ADDR_W'(1);
      end
   end

   // Main sequencer. Every output is a register written here, so sample_valid
   // is raised on the transition into OUT_FIRST/OUT_SECOND and is high for
   // exactly the one cycle spent in either of those states. Ticks that land
   // in REQ, WAIT_DATA, OUT_FIRST or OUT_SECOND simply fall through and are
   // lost. A pending restart is only consumed where the FSM (re)enters IDLE,
   // which keeps an in-flight word intact and lets restart win over the
   // normal address advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_read        <= 1'b0;
         r_addr        <= START_ADDR;
         r_data        <= '0;
         r_dirQ        <= 1'b0;
         r_restartPend <= 1'b0;
         r_sampleOut   <= '0;
         r_sampleValid <= 1'b0;
      end else begin
         r_sampleValid <= 1'b0;
         if (i_restart) begin
            r_restartPend <= 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (w_restartNow) begin
                  r_addr        <= w_restartAddr;
                  r_restartPend <= 1'b0;
               end else if (w_tickGo) begin
                  r_dirQ  <= i_dir;
                  r_read  <= 1'b1;
                  r_state <= REQ;
               end
            end
            REQ: begin
               if (!flash.flash_waitrequest) begin
                  r_read  <= 1'b0;
                  r_state <= WAIT_DATA;
               end
            end
            WAIT_DATA: begin
               if (flash.flash_readdatavalid) begin
                  r_data        <= flash.flash_readdata;
                  r_sampleOut   <= r_dirQ ? flash.flash_readdata[31:16]
                                          : flash.flash_readdata[15:0];
                  r_sampleValid <= 1'b1;
                  r_state       <= OUT_FIRST;
               end
            end
            OUT_FIRST: begin
               r_state <= WAIT_TICK;
            end
            WAIT_TICK: begin
               if (w_tickGo) begin
                  r_sampleOut   <= r_dirQ ? r_data[15:0] : r_data[31:16];
                  r_sampleValid <= 1'b1;
                  r_state       <= OUT_SECOND;
               end
            end
            OUT_SECOND: begin
               if (w_restartNow) begin
                  r_addr        <= w_restartAddr;
                  r_restartPend <= 1'b0;
               end else begin
                  r_addr <= w_nextAddr;
               end
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign flash.flash_read       = r_read;
   assign flash.flash_address    = r_addr;
   assign flash.flash_byteenable = 4'hF;
   assign o_sample_out           = r_sampleOut;
   assign o_sample_valid         = r_sampleValid;

endmodule

// File: doc/flash_sample_sequencer.md
Name: flash_sample_sequencer

Overview:
Downstream consumer of flash read transactions in the audio playback path. Each sample_tick, while playing, it supplies the next 16-bit audio sample to the audio output stage. It issues one 32-bit flash read per pair of samples and splits the word into two halves. It steps the word address forward or backward with wrap-around and supports pause and restart.

Parameters:
ADDR_W, 23, flash word-address width
START_ADDR, 23'h000000, first word of the sample region
END_ADDR, 23'h07FFFF, last word of the sample region, inclusive; END_ADDR > START_ADDR

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active-low
sample_tick  in  1  one-cycle pulse, already in clk domain, requesting the next sample
play  in  1  level; 1 = run, 0 = pause
dir  in  1  0 = forward, 1 = backward
restart  in  1  one-cycle pulse; return to region start (forward) or end (backward)
flash_waitrequest  in  1  flash controller busy
flash_readdatavalid  in  1  flash_readdata valid this cycle
flash_readdata  in  32  flash word
flash_read  out  1  read request; held until accepted
flash_address  out  ADDR_W  word address of current request
flash_byteenable  out  4  constant 4'hF
sample_out  out  16  current sample, two's complement
sample_valid  out  1  one-cycle pulse when sample_out updates

Behaviour:
- Reset, asynchronous while rst_n=0:
  - state IDLE, flash_read=0, flash_address=START_ADDR
  - sample_out=0, sample_valid=0, data latch=0, dir_q=0, restart_pend=0
  - An in-flight flash read is abandoned; readdatavalid arriving after reset release in IDLE is ignored.
- All outputs are registered. sample_valid is high for exactly one cycle per emitted sample.
- States and transitions:
  - IDLE: if sample_tick && play, latch dir_q<=dir, go to REQ. Otherwise stay.
  - REQ: flash_read=1, flash_address stable. If !flash_waitrequest, go to WAIT_DATA; flash_read=0 from the next cycle.
  - WAIT_DATA: on flash_readdatavalid, latch flash_readdata, go to OUT_FIRST.
  - OUT_FIRST: sample_valid=1. sample_out = data[15:0] if dir_q=0, else data[31:16]. Go to WAIT_TICK.
  - WAIT_TICK: if sample_tick && play, go to OUT_SECOND.
  - OUT_SECOND: sample_valid=1, sample_out = the other half. Update address. Go to IDLE.
- Latency: tick in IDLE at cycle 0 -> flash_read=1 at cycle 1. With waitrequest=0 at cycle 1 and readdatavalid at cycle k, sample_valid=1 at cycle k+1.
- Address update, in OUT_SECOND, using dir_q:
  - forward: END_ADDR wraps to START_ADDR, else +1
  - backward: START_ADDR wraps to END_ADDR, else -1
- Restart: a restart pulse in any state sets restart_pend. It is applied at the next entry to IDLE, or immediately if already in IDLE: flash_address <= (dir ? END_ADDR : START_ADDR), then restart_pend clears.
  - Restart overrides the OUT_SECOND advance in the same cycle.
  - Restart and tick in IDLE in the same cycle: the restart address is loaded first, the tick is deferred, and the state stays in IDLE that cycle.
- Ticks arriving in REQ, WAIT_DATA, OUT_FIRST or OUT_SECOND are dropped, not queued.
- Pause (play=0):
  - Blocks ticks in IDLE and WAIT_TICK.
  - A transaction already in REQ or WAIT_DATA completes, and OUT_FIRST still emits its sample.
- A dir change takes effect only at the next IDLE->REQ; half order within a word never changes mid-word.
- readdatavalid outside WAIT_DATA is ignored.
- flash_byteenable=4'hF at all times, including reset.

Test Plan:
- Reset, then tick with play=1, dir=0, waitrequest=0, readdatavalid 3 cycles after accept with data 32'hBBBB_AAAA -> flash_read high 1 cycle at address 0; sample_valid with 16'hAAAA; next tick -> 16'hBBBB; flash_address becomes 1.
- dir=1 from reset -> restart pulse loads 23'h07FFFF. Same data -> samples 16'hBBBB then 16'hAAAA; address becomes 23'h07FFFE.
- Forward wrap: force address END_ADDR, complete a word -> flash_address=START_ADDR. Backward at START_ADDR -> END_ADDR.
- Hold flash_waitrequest=1 for 5 cycles -> flash_read and flash_address stable all 5 cycles; WAIT_DATA entered the cycle after waitrequest drops.
- play=0 in WAIT_TICK with 10 ticks -> no sample_valid. play=1 plus tick -> second half emitted once.
- Restart pulse during WAIT_DATA with address 5 -> first half still emitted. Address after OUT_SECOND is START_ADDR, not 6. Assert rst_n=0 mid-REQ -> flash_read=0 immediately.
